arcade_led_driver: RTL and testbench

ARCADE_LED_DRIVER -- requirements
Module: arcade_led_driver

---
 rtl/arcade_led_driver.sv | 173 +++++++++++++++++
 tb/tb_arcade_led_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_led_driver.sv
// Arcade cabinet LED driver: latches OFF/ON/BLINK/FLASH_N commands, times the
// on/off phases with a tick prescaler and dims the lit phase with a free-running PWM.
module arcade_led_driver #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [7:0]          cmd_period,
    input  logic [3:0]          cmd_count,
    input  logic [PWM_BITS-1:0] cmd_bright,
    output logic                busy,
    output logic                done,
    output logic                ARCADE_LED
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_FLASH = 2'b11;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_ON    = 2'd1,
        S_BLINK = 2'd2,
        S_FLASH = 2'd3
    } state_t;

    // A latched half-period of zero behaves exactly like a half-period of one.
    function automatic logic [7:0] eff_period(input logic [7:0] p);
        return (p == 8'd0) ? 8'd1 : p;
    endfunction

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [7:0]          tick_cnt_q, tick_cnt_d;
    logic                phase_q, phase_d;
    logic [3:0]          flash_cnt_q, flash_cnt_d;
    logic [7:0]          period_q, period_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                zero_pend_q, zero_pend_d;
    logic                led_q, led_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;

    logic                accept_s;
    logic                tick_s;
    logic                phase_end_s;
    logic                finish_s;
    logic                light_s;
    logic [7:0]          period_last_s;

    assign accept_s      = cmd_valid && ready_q;
    assign tick_s        = (presc_q == PRE_LAST);
    assign period_last_s = eff_period(period_q) - 8'd1;
    assign phase_end_s   = tick_s && (tick_cnt_q == period_last_s);

    // Light condition and next-state computation for every register
    always_comb begin
        state_d     = state_q;
        presc_d     = tick_s ? {PRE_W{1'b0}} : (presc_q + PRE_W'(1));
        tick_cnt_d  = tick_cnt_q;
        phase_d     = phase_q;
        flash_cnt_d = flash_cnt_q;
        period_d    = period_q;
        bright_d    = bright_q;
        pwm_d       = pwm_q + PWM_BITS'(1);
        zero_pend_d = 1'b0;
        finish_s    = 1'b0;

        light_s = (state_q != S_OFF) && phase_q &&
                  ((bright_q == {PWM_BITS{1'b1}}) || (pwm_q < bright_q));

        if (accept_s) begin
            presc_d     = {PRE_W{1'b0}};
            tick_cnt_d  = 8'd0;
            phase_d     = 1'b1;
            flash_cnt_d = cmd_count;
            period_d    = cmd_period;
            bright_d    = cmd_bright;
            case (cmd_mode)
                MODE_OFF:   state_d = S_OFF;
                MODE_ON:    state_d = S_ON;
                MODE_BLINK: state_d = S_BLINK;
                MODE_FLASH: begin
                    // A zero-length flash sequence completes without entering FLASH.
                    if (cmd_count == 4'd0) begin
                        state_d     = S_OFF;
                        zero_pend_d = 1'b1;
                    end else begin
                        state_d = S_FLASH;
                    end
                end
                default:    state_d = S_OFF;
            endcase
        end else if (tick_s && ((state_q == S_BLINK) || (state_q == S_FLASH))) begin
            if (!phase_end_s) begin
                tick_cnt_d = tick_cnt_q + 8'd1;
            end else begin
                tick_cnt_d = 8'd0;
                case (state_q)
                    S_BLINK: phase_d = ~phase_q;
                    S_FLASH: begin
                        if (phase_q) begin
                            phase_d = 1'b0;
                        end else if (flash_cnt_q <= 4'd1) begin
                            state_d  = S_OFF;
                            finish_s = 1'b1;
                        end else begin
                            flash_cnt_d = flash_cnt_q - 4'd1;
                            phase_d     = 1'b1;
                        end
                    end
                    default: phase_d = phase_q;
                endcase
            end
        end else begin
            tick_cnt_d = tick_cnt_q;
        end

        led_d   = light_s;
        done_d  = finish_s || zero_pend_q;
        busy_d  = (state_d == S_FLASH);
        ready_d = (state_d != S_FLASH);
    end

    // State, counters, latched command fields and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_OFF;
            presc_q     <= {PRE_W{1'b0}};
            tick_cnt_q  <= 8'd0;
            phase_q     <= 1'b0;
            flash_cnt_q <= 4'd0;
            period_q    <= 8'd0;
            bright_q    <= {PWM_BITS{1'b0}};
            pwm_q       <= {PWM_BITS{1'b0}};
            zero_pend_q <= 1'b0;
            led_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            tick_cnt_q  <= tick_cnt_d;
            phase_q     <= phase_d;
            flash_cnt_q <= flash_cnt_d;
            period_q    <= period_d;
            bright_q    <= bright_d;
            pwm_q       <= pwm_d;
            zero_pend_q <= zero_pend_d;
            led_q       <= led_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ARCADE_LED = led_q;

endmodule

// File: tb/tb_arcade_led_driver.sv
// Randomised scoreboard bench for arcade_led_driver: a cycle-level model derives
// expected outputs from elapsed time since each accepted command.
module tb_arcade_led_driver;

    localparam int TD = 4;
    localparam int PB = 4;

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_mode;
    logic [7:0]    cmd_period;
    logic [3:0]    cmd_count;
    logic [PB-1:0] cmd_bright;
    logic          busy;
    logic          done;
    logic          ARCADE_LED;

    arcade_led_driver #(.TICK_DIV(TD), .PWM_BITS(PB)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_period (cmd_period),
        .cmd_count  (cmd_count),
        .cmd_bright (cmd_bright),
        .busy       (busy),
        .done       (done),
        .ARCADE_LED (ARCADE_LED)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic led;
        logic busy;
        logic done;
        logic ready;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: what was accepted and how many cycles ago.
    int m_mode;   // 0 off, 1 on, 2 blink, 3 flash
    int m_t;
    int m_per;
    int m_cnt;
    int m_bright;
    int m_edges;
    bit m_zero_pend;

    function automatic bit model_light();
        bit on;
        int n;
        int pwm;
        if (m_mode == 0) return 1'b0;
        if (m_mode == 1) begin
            on = 1'b1;
        end else begin
            n  = m_t / TD;
            on = ((n / m_per) % 2) == 0;
        end
        pwm = m_edges % (1 << PB);
        return on && ((m_bright == (1 << PB) - 1) || (pwm < m_bright));
    endfunction

    task automatic model_reset();
        m_mode      = 0;
        m_t         = 0;
        m_per       = 1;
        m_cnt       = 0;
        m_bright    = 0;
        m_edges     = 0;
        m_zero_pend = 1'b0;
    endtask

    // Advance the model across one rising edge and queue the outputs expected after it.
    task automatic model_step();
        exp_t e;
        bit   led;
        bit   dn;
        if (reset) begin
            model_reset();
            e = '{led: 1'b0, busy: 1'b0, done: 1'b0, ready: 1'b1};
        end else begin
            led         = model_light();
            dn          = m_zero_pend;
            m_zero_pend = 1'b0;
            if (cmd_valid && (m_mode != 3)) begin
                m_per    = (cmd_period == 8'd0) ? 1 : int'(cmd_period);
                m_cnt    = int'(cmd_count);
                m_bright = int'(cmd_bright);
                m_t      = 0;
                m_mode   = int'(cmd_mode);
                if (m_mode == 3 && m_cnt == 0) begin
                    m_mode      = 0;
                    m_zero_pend = 1'b1;
                end
            end else begin
                m_t = m_t + 1;
                if (m_mode == 3 && m_t == 2 * m_per * m_cnt * TD) begin
                    m_mode = 0;
                    dn     = 1'b1;
                end
            end
            m_edges = m_edges + 1;
            e = '{led: led, busy: (m_mode == 3), done: dn, ready: (m_mode != 3)};
        end
        exp_q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    // Monitor: compare every presented output set against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ARCADE_LED", ARCADE_LED, e.led);
                check("busy", busy, e.busy);
                check("done", done, e.done);
                check("cmd_ready", cmd_ready, e.ready);
            end
        end
    end

    task automatic issue(input logic [1:0] mode, input logic [7:0] per,
                         input logic [3:0] cnt, input logic [PB-1:0] br);
        cmd_mode   = mode;
        cmd_period = per;
        cmd_count  = cnt;
        cmd_bright = br;
        cmd_valid  = 1'b1;
        @(negedge clock);
        cmd_valid  = 1'b0;
        cmd_mode   = 2'($urandom);
        cmd_period = 8'($urandom);
        cmd_count  = 4'($urandom);
        cmd_bright = PB'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_mode   = 2'b00;
        cmd_period = 8'd0;
        cmd_count  = 4'd0;
        cmd_bright = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // ON full brightness right after release, then a steady window.
        issue(2'b01, 8'd0, 4'd0, 4'd15);
        idle(20);
        // BLINK period 2, interrupted by OFF mid-pattern.
        issue(2'b10, 8'd2, 4'd0, 4'd15);
        idle(45);
        issue(2'b00, 8'd0, 4'd0, 4'd0);
        idle(5);
        // FLASH_N 3x period 1, with a command attempt while flashing.
        issue(2'b11, 8'd1, 4'd3, 4'd15);
        idle(6);
        issue(2'b01, 8'd0, 4'd0, 4'd15);
        idle(25);
        // Dimmed and dark ON.
        issue(2'b01, 8'd0, 4'd0, 4'd4);
        idle(40);
        issue(2'b01, 8'd0, 4'd0, 4'd0);
        idle(20);
        // FLASH_N with zero count, then period 0.
        issue(2'b11, 8'd3, 4'd0, 4'd15);
        idle(6);
        issue(2'b10, 8'd0, 4'd0, 4'd15);
        idle(20);
        // FLASH_N 5x aborted by an asynchronous reset during an on-phase.
        issue(2'b11, 8'd2, 4'd5, 4'd15);
        idle(3);
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        exp_q.push_back('{led: 1'b0, busy: 1'b0, done: 1'b0, ready: 1'b1});
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        idle(10);

        // Random command mix, including commands offered while busy.
        for (int i = 0; i < 80; i++) begin
            issue(2'($urandom), 8'($urandom_range(0, 3)),
                  4'($urandom_range(0, 5)),
                  ($urandom_range(0, 3) == 0) ? 4'd15 : PB'($urandom));
            idle($urandom_range(0, 40));
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
